// File: rtl/vend_pkg.sv
// vend_pkg: shared state encoding, coin values and change-strobe helpers
// for the vending controller.
package vend_pkg;
    typedef enum logic [3:0] {
        IDLE    = 4'b0001,
        COLLECT = 4'b0010,
        VEND    = 4'b0100,
        PAYOUT  = 4'b1000
    } state_t;

    localparam logic [2:0] CHANGE_2FL = 3'b100;
    localparam logic [2:0] CHANGE_1FL = 3'b010;
    localparam logic [2:0] CHANGE_1SH = 3'b001;

    localparam logic [3:0] SHILLING = 4'd1;
    localparam logic [3:0] FLORIN   = 4'd2;

    // Greedy choice of the next coin to pay out for a given amount owed
    function automatic logic [2:0] change_code(input logic [3:0] r);
        return r >= 4'd4 ? CHANGE_2FL : r >= 4'd2 ? CHANGE_1FL : r != 4'd0 ? CHANGE_1SH : 3'b000;
    endfunction

    function automatic logic [3:0] change_value(input logic [2:0] c);
        return c[2] ? 4'd4 : c[1] ? 4'd2 : {3'b000, c[0]};
    endfunction
endpackage

// File: rtl/vend_controller_pulse_timer.sv
// pulse_timer: loadable down-counter; done is high while the count sits at zero.
module pulse_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);
    logic [W-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (count != '0)
            count <= count - 1'b1;
    end

    assign done = count == '0;
endmodule

// File: rtl/vend_controller.sv
// vend_controller: coin-operated gruel vending FSM; accumulates credit, dispenses,
// then pays change or a cancel refund as timed strobes with gaps between them.
module vend_controller
    import vend_pkg::*;
#(
    parameter int PRICE        = 3,
    parameter int PULSE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       coin_shilling,
    input  logic       coin_florin,
    input  logic       cancel,
    output logic [3:0] state,
    output logic       gruel,
    output logic [2:0] change,
    output logic       coin_reject,
    output logic [3:0] credit
);
    localparam int         TW      = $clog2(PULSE_CYCLES + 1);
    localparam logic [3:0] PRICE_V = 4'(PRICE);

    state_t     st;
    logic [3:0] remain;
    logic [3:0] add;
    logic [3:0] sum;
    logic       gap;
    logic       busy;
    logic       to_vend;
    logic       to_refund;
    logic       load;
    logic       done;

    assign state     = st;
    assign add       = (coin_shilling ? SHILLING : 4'd0) + (coin_florin ? FLORIN : 4'd0);
    assign sum       = credit + add;
    assign busy      = st == VEND || st == PAYOUT;
    // A coin arriving with cancel is counted first, so reaching the price wins over the refund
    assign to_vend   = !busy && sum >= PRICE_V;
    assign to_refund = st == COLLECT && cancel && !to_vend;
    assign load      = to_vend || to_refund || (busy && done);

    pulse_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (load),
        .load_val (TW'(PULSE_CYCLES - 1)),
        .done     (done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st          <= IDLE;
            credit      <= '0;
            remain      <= '0;
            gap         <= 1'b0;
            gruel       <= 1'b0;
            change      <= '0;
            coin_reject <= 1'b0;
        end else begin
            coin_reject <= busy && (coin_shilling || coin_florin);
            case (st)
                IDLE, COLLECT: begin
                    if (to_vend) begin
                        st     <= VEND;
                        credit <= sum;
                        remain <= sum - PRICE_V;
                        gruel  <= 1'b1;
                    end else if (to_refund) begin
                        st     <= PAYOUT;
                        credit <= '0;
                        remain <= sum;
                        change <= change_code(sum);
                        gap    <= 1'b0;
                    end else begin
                        st     <= sum != 4'd0 ? COLLECT : IDLE;
                        credit <= sum;
                    end
                end
                VEND: begin
                    credit <= '0;
                    if (done) begin
                        gruel  <= 1'b0;
                        change <= change_code(remain);
                        gap    <= 1'b0;
                        st     <= remain != 4'd0 ? PAYOUT : IDLE;
                    end
                end
                PAYOUT: begin
                    // Alternate strobe-high and gap phases; the amount owed drops as each strobe ends
                    if (done && !gap) begin
                        change <= '0;
                        remain <= remain - change_value(change);
                        gap    <= 1'b1;
                    end else if (done) begin
                        change <= change_code(remain);
                        gap    <= 1'b0;
                        st     <= remain == 4'd0 ? IDLE : PAYOUT;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule
